// File: rtl/camellia_subkey_sequencer_if.sv
// camellia_subkey_sequencer_if: key-load and subkey-stream bundle for the Camellia-128 subkey sequencer
//   key_valid/key_ready : handshake for loading a KL/KA pair
//   kl, ka              : 128-bit user key and derived key
//   sk_valid/sk_ready   : handshake for one 64-bit subkey beat
//   sk                  : current subkey
//   sk_idx              : stream position 0..25
//   sk_is_ke            : beat is ke1..ke4 (FL/FLINV keys)
//   sk_last             : beat is kw4
//   master = sequencer side, slave = key source / round datapath side
interface camellia_subkey_sequencer_if #(
    parameter int IDX_W = 5
);
    logic             key_valid;
    logic             key_ready;
    logic [127:0]     kl;
    logic [127:0]     ka;
    logic             sk_valid;
    logic             sk_ready;
    logic [63:0]      sk;
    logic [IDX_W-1:0] sk_idx;
    logic             sk_is_ke;
    logic             sk_last;
    modport master (
        input  key_valid, kl, ka, sk_ready,
        output key_ready, sk_valid, sk, sk_idx, sk_is_ke, sk_last
    );
    modport slave (
        output key_valid, kl, ka, sk_ready,
        input  key_ready, sk_valid, sk, sk_idx, sk_is_ke, sk_last
    );
endinterface

// File: rtl/camellia_subkey_sequencer.sv
// camellia_subkey_sequencer: streams the 26 Camellia-128 subkeys derived from KL/KA in consumption order
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : camellia_subkey_sequencer_if.master (key load handshake in, subkey stream handshake out)
module camellia_subkey_sequencer #(
    parameter int N_SUBKEYS = 26,
    parameter int IDX_W     = 5
) (
    input logic                          clk,
    input logic                          rst,
    camellia_subkey_sequencer_if.master  bus
);
    typedef enum logic {IDLE, STREAM} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SUBKEYS - 1);
    state_t           state;
    logic [127:0]     kl_q;
    logic [127:0]     ka_q;
    logic [IDX_W-1:0] nxt;
    logic             nxt_ke;
    assign nxt    = bus.sk_idx + IDX_W'(1);
    assign nxt_ke = nxt == IDX_W'(8) || nxt == IDX_W'(9) || nxt == IDX_W'(16) || nxt == IDX_W'(17);
    function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
        return (x << n) | (x >> (128 - n));
    endfunction
    // Subkeys come in H/L pairs of one rotated key, so idx[4:1] picks the rotation and idx[0] the half;
    // the only pair that mixes sources is k9/k10 (KA<<<45 H, KL<<<60 L).
    function automatic logic [63:0] subkey(input logic [IDX_W-1:0] i, input logic [127:0] kl,
                                           input logic [127:0] ka);
        logic [127:0] r;
        case (i[4:1])
            4'd0:    r = kl;
            4'd1:    r = ka;
            4'd2:    r = rotl(kl, 15);
            4'd3:    r = rotl(ka, 15);
            4'd4:    r = rotl(ka, 30);
            4'd5:    r = rotl(kl, 45);
            4'd6:    r = i[0] ? rotl(kl, 60) : rotl(ka, 45);
            4'd7:    r = rotl(ka, 60);
            4'd8:    r = rotl(kl, 77);
            4'd9:    r = rotl(kl, 94);
            4'd10:   r = rotl(ka, 94);
            4'd11:   r = rotl(kl, 111);
            4'd12:   r = rotl(ka, 111);
            default: r = '0;
        endcase
        return i[0] ? r[63:0] : r[127:64];
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            kl_q          <= '0;
            ka_q          <= '0;
            bus.key_ready <= 1'b1;
            bus.sk_valid  <= 1'b0;
            bus.sk        <= '0;
            bus.sk_idx    <= '0;
            bus.sk_is_ke  <= 1'b0;
            bus.sk_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.key_valid) begin
                    // first beat is built from the incoming key since kl_q/ka_q load on the same edge
                    kl_q          <= bus.kl;
                    ka_q          <= bus.ka;
                    bus.key_ready <= 1'b0;
                    bus.sk_valid  <= 1'b1;
                    bus.sk        <= subkey('0, bus.kl, bus.ka);
                    bus.sk_idx    <= '0;
                    bus.sk_is_ke  <= 1'b0;
                    bus.sk_last   <= 1'b0;
                    state         <= STREAM;
                end
                STREAM: if (bus.sk_ready) begin
                    if (bus.sk_idx == LAST) begin
                        bus.key_ready <= 1'b1;
                        bus.sk_valid  <= 1'b0;
                        bus.sk        <= '0;
                        bus.sk_idx    <= '0;
                        bus.sk_is_ke  <= 1'b0;
                        bus.sk_last   <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        bus.sk       <= subkey(nxt, kl_q, ka_q);
                        bus.sk_idx   <= nxt;
                        bus.sk_is_ke <= nxt_ke;
                        bus.sk_last  <= nxt == LAST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
